spi_host_master: RTL

Host-side SPI master that drives the pins of the SPI memory slave (sclk, cs, mosi) and captures miso. It sits directly upstream of the memory. It turns a single-cycle parallel request (7-bit address, R/W, 8-bit write data) into one 16-bit SPI frame, returns read data and pulses completion. Mode 0 framing: sclk idles low, the slave samples on the sclk rising edge and drives miso after the falling edge.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_sclk_gen.sv | 56 +++++
 rtl/spi_host_master.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants, state encoding and frame helper for the SPI host master.
package spi_pkg;

    localparam int   ADDR_W  = 7;
    localparam int   DATA_W  = 8;
    localparam int   FRAME_W = 16;
    localparam logic RW_READ = 1'b1;

    // Width of the phase/cycle counters; wide enough for any sane timing parameter.
    localparam int   CNT_W   = 16;
    localparam int   BIT_W   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    // Serial frame sent MSB first: address, R/W flag, then data (zeros for reads).
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] data_s;
        if (rw == RW_READ) begin
            data_s = {DATA_W{1'b0}};
        end else begin
            data_s = wdata;
        end
        build_frame = {addr, rw, data_s};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: while enabled, produces a mode-0 clock with HALF_PERIOD clk
// cycles per phase, starting with a low phase. Ticks mark the cycle whose
// closing clk edge flips sclk, so the master can act on that same edge.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;
    logic             sclk_q;
    logic             sclk_d;
    logic             phase_end_s;

    assign phase_end_s = enable && (div_q == CNT_W'(HALF_PERIOD - 1));

    // Divider and sclk registers; sclk leaves a flop so the pin is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= {CNT_W{1'b0}};
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    // Count each half period and toggle at its end; cleared and low while disabled.
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!enable) begin
            div_d  = {CNT_W{1'b0}};
            sclk_d = 1'b0;
        end else if (phase_end_s) begin
            div_d  = {CNT_W{1'b0}};
            sclk_d = ~sclk_q;
        end else begin
            div_d  = div_q + CNT_W'(1);
            sclk_d = sclk_q;
        end
    end

    assign sclk      = sclk_q;
    assign rise_tick = phase_end_s && !sclk_q;
    assign fall_tick = phase_end_s && sclk_q;

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 host master: converts one parallel request into a 16-bit frame
// {addr, rw, data}, captures the read byte from miso and pulses done.
module spi_host_master
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = 5,
    parameter int SETUP_CYC   = 5,
    parameter int HOLD_CYC    = 5,
    parameter int GAP_CYC     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    spi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               rw_q, rw_d;
    logic               cs_q, cs_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               rise_tick_s;
    logic               fall_tick_s;
    logic               shift_en_s;
    logic [FRAME_W-1:0] frame_s;

    assign shift_en_s = (state_q == SHIFT);
    assign frame_s    = build_frame(rw, addr, wdata);

    spi_sclk_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .enable    (shift_en_s),
        .sclk      (sclk),
        .rise_tick (rise_tick_s),
        .fall_tick (fall_tick_s)
    );

    // State, counters, shift registers and pin/handshake output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= {CNT_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            tx_q    <= {FRAME_W{1'b0}};
            rx_q    <= {DATA_W{1'b0}};
            rw_q    <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rw_q    <= rw_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: timed SETUP/HOLD/GAP phases and 16-bit SHIFT counted on sclk falls.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        case (state_q)
            IDLE: begin
                cyc_d = {CNT_W{1'b0}};
                bit_d = {BIT_W{1'b0}};
                if (start) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cyc_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = SHIFT;
                    cyc_d   = {CNT_W{1'b0}};
                end else begin
                    cyc_d   = cyc_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                cyc_d = {CNT_W{1'b0}};
                if (fall_tick_s) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                        bit_d   = {BIT_W{1'b0}};
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    bit_d = bit_q;
                end
            end
            HOLD: begin
                if (cyc_q == CNT_W'(HOLD_CYC - 1)) begin
                    state_d = GAP;
                    cyc_d   = {CNT_W{1'b0}};
                end else begin
                    cyc_d   = cyc_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cyc_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                    cyc_d   = {CNT_W{1'b0}};
                end else begin
                    cyc_d   = cyc_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = {CNT_W{1'b0}};
                bit_d   = {BIT_W{1'b0}};
            end
        endcase
    end

    // Datapath and outputs: latch the frame, shift mosi on falls, miso on rises.
    always_comb begin
        tx_d    = tx_q;
        rx_d    = rx_q;
        rw_d    = rw_q;
        mosi_d  = mosi_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d   = frame_s;
                    rw_d   = rw;
                    rx_d   = {DATA_W{1'b0}};
                    mosi_d = frame_s[FRAME_W-1];
                end else begin
                    mosi_d = 1'b0;
                end
            end
            SETUP: begin
                mosi_d = tx_q[FRAME_W-1];
            end
            SHIFT: begin
                // Data phase is bits 8..15, i.e. bit index MSB set.
                if (rise_tick_s && bit_q[BIT_W-1] && (rw_q == RW_READ)) begin
                    rx_d = {rx_q[DATA_W-2:0], miso};
                end else begin
                    rx_d = rx_q;
                end
                if (fall_tick_s) begin
                    if (bit_q == BIT_LAST) begin
                        mosi_d = 1'b0;
                    end else begin
                        tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
                        mosi_d = tx_q[FRAME_W-2];
                    end
                end else begin
                    mosi_d = mosi_q;
                end
            end
            HOLD: begin
                mosi_d = 1'b0;
            end
            GAP: begin
                mosi_d = 1'b0;
                if ((state_d == IDLE) && (rw_q == RW_READ)) begin
                    rdata_d = rx_q;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            default: begin
                mosi_d = 1'b0;
            end
        endcase
        cs_d   = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        busy_d = (state_d != IDLE);
        done_d = (state_q == GAP) && (state_d == IDLE);
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;

endmodule
